// File: rtl/cpu_pkg.sv
// Shared CPU types and default widths for the rename/status table.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned REG_W = $clog2(NREG);
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rename_entry_t;

endpackage

// File: rtl/rename_table_if.sv
// Dispatch-side bundle: commit, rename request/response and branch resolution.
interface rename_table_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned NCKPT = 4
);
    localparam int unsigned REG_W = $clog2(NREG);
    localparam int unsigned CK_W  = $clog2(NCKPT);

    logic                   rdy;
    logic                   cm_valid;
    logic [REG_W-1:0]       cm_dest;
    logic [TAG_W-1:0]       cm_tag;
    logic [XLEN-1:0]        cm_value;
    logic                   flush;
    logic                   rn_valid;
    logic [TAG_W-1:0]       rn_id;
    logic [NSRC-1:0]        rn_src_valid;
    logic [NSRC*REG_W-1:0]  rn_src_reg;
    logic                   rn_dest_valid;
    logic [REG_W-1:0]       rn_dest_reg;
    logic [TAG_W-1:0]       rn_dest_tag;
    logic                   rn_ckpt;
    logic                   rn_done;
    logic [TAG_W-1:0]       rn_done_id;
    logic [NSRC-1:0]        src_busy;
    logic [NSRC*TAG_W-1:0]  src_tag;
    logic [NSRC*XLEN-1:0]   src_value;
    logic [CK_W-1:0]        ckpt_id;
    logic                   ckpt_full;
    logic                   br_valid;
    logic [CK_W-1:0]        br_id;
    logic                   br_mispredict;

    modport master (
        output rdy, cm_valid, cm_dest, cm_tag, cm_value, flush,
        output rn_valid, rn_id, rn_src_valid, rn_src_reg,
        output rn_dest_valid, rn_dest_reg, rn_dest_tag, rn_ckpt,
        output br_valid, br_id, br_mispredict,
        input  rn_done, rn_done_id, src_busy, src_tag, src_value, ckpt_id, ckpt_full
    );

    modport slave (
        input  rdy, cm_valid, cm_dest, cm_tag, cm_value, flush,
        input  rn_valid, rn_id, rn_src_valid, rn_src_reg,
        input  rn_dest_valid, rn_dest_reg, rn_dest_tag, rn_ckpt,
        input  br_valid, br_id, br_mispredict,
        output rn_done, rn_done_id, src_busy, src_tag, src_value, ckpt_id, ckpt_full
    );

endinterface

// File: rtl/rename_ckpt_bank.sv
// Ring of branch snapshots of the busy/rename table, kept current by commits so a
// mispredict restore reflects everything that retired since the snapshot.
module rename_ckpt_bank #(
    parameter int unsigned NREG  = cpu_pkg::NREG,
    parameter int unsigned TAG_W = cpu_pkg::TAG_W,
    parameter int unsigned NCKPT = 4,
    localparam int unsigned REG_W = $clog2(NREG),
    localparam int unsigned CK_W  = $clog2(NCKPT)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                rdy,
    input  logic                                flush,
    input  logic                                alloc,
    input  cpu_pkg::rename_entry_t [NREG-1:0]   snap,
    input  logic                                br_valid,
    input  logic                                br_mispredict,
    input  logic [CK_W-1:0]                     br_id,
    input  logic                                cm_valid,
    input  logic [REG_W-1:0]                    cm_dest,
    input  logic [TAG_W-1:0]                    cm_tag,
    output cpu_pkg::rename_entry_t [NREG-1:0]   restore,
    output logic [CK_W-1:0]                     tail,
    output logic                                full
);
    import cpu_pkg::*;

    rename_entry_t [NREG-1:0] slot_q [NCKPT];
    logic [NCKPT-1:0]         valid_q;
    logic [NCKPT-1:0]         kill;
    logic [CK_W-1:0]          tail_q;
    logic [CK_W-1:0]          span;
    logic                     cm_hit;

    assign cm_hit = cm_valid && (cm_dest != '0);
    assign span   = tail_q - br_id;
    assign tail   = tail_q;
    assign full   = valid_q[tail_q];

    // Slots from br_id up to (not incl.) tail are younger; span 0 means the ring is full.
    always_comb begin
        kill = '0;
        for (int i = 0; i < NCKPT; i++) begin
            if ((CK_W'(i) - br_id) < span || span == '0) kill[i] = 1'b1;
        end
    end

    always_comb begin
        restore = slot_q[br_id];
        if (cm_hit && restore[cm_dest].tag == cm_tag) restore[cm_dest].busy = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tail_q  <= '0;
            for (int i = 0; i < NCKPT; i++) slot_q[i] <= '0;
        end else if (rdy) begin
            if (cm_hit) begin
                for (int i = 0; i < NCKPT; i++) begin
                    if (valid_q[i] && slot_q[i][cm_dest].tag == cm_tag) begin
                        slot_q[i][cm_dest].busy <= 1'b0;
                    end
                end
            end
            if (flush) begin
                valid_q <= '0;
                tail_q  <= '0;
            end else if (br_valid && br_mispredict) begin
                valid_q <= valid_q & ~kill;
                tail_q  <= br_id;
            end else begin
                if (br_valid) valid_q[br_id] <= 1'b0;
                if (alloc) begin
                    valid_q[tail_q] <= 1'b1;
                    slot_q[tail_q]  <= snap;
                    tail_q          <= tail_q + 1'b1;
                end
            end
        end
    end

    a_br_valid_slot: assert property (@(posedge clk) disable iff (!rst_n)
        rdy && br_valid |-> valid_q[br_id]);

endmodule

// File: rtl/rename_table.sv
// Live register value/busy/rename table with one-cycle operand lookup, commit bypass,
// branch checkpoint restore and full flush.
module rename_table #(
    parameter int unsigned XLEN  = cpu_pkg::XLEN,
    parameter int unsigned NREG  = cpu_pkg::NREG,
    parameter int unsigned TAG_W = cpu_pkg::TAG_W,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned NCKPT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rename_table_if.slave bus
);
    localparam int unsigned REG_W = $clog2(NREG);
    localparam int unsigned CK_W  = $clog2(NCKPT);
    import cpu_pkg::*;

    logic [XLEN-1:0]          value_q [NREG];
    rename_entry_t [NREG-1:0] ent_q, ent_d, restore;
    logic [CK_W-1:0]          tail;
    logic                     full, mispredict, accept, alloc, cm_hit;
    logic [NSRC-1:0]          lk_busy;
    logic [NSRC*TAG_W-1:0]    lk_tag;
    logic [NSRC*XLEN-1:0]     lk_value;

    logic                     rn_done_q;
    logic [TAG_W-1:0]         rn_done_id_q;
    logic [NSRC-1:0]          src_busy_q;
    logic [NSRC*TAG_W-1:0]    src_tag_q;
    logic [NSRC*XLEN-1:0]     src_value_q;
    logic [CK_W-1:0]          ckpt_id_q;

    assign mispredict = bus.br_valid && bus.br_mispredict;
    assign accept     = bus.rdy && bus.rn_valid && !bus.flush && !mispredict;
    assign alloc      = accept && bus.rn_ckpt;
    assign cm_hit     = bus.cm_valid && (bus.cm_dest != '0);

    // Lookups see the table before this cycle's rename; a matching commit bypasses.
    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [REG_W-1:0] rs;
        logic             bypass;
        assign rs     = bus.rn_src_reg[s*REG_W +: REG_W];
        assign bypass = cm_hit && (bus.cm_dest == rs) && (ent_q[rs].tag == bus.cm_tag);
        assign lk_busy[s] = bus.rn_src_valid[s] && ent_q[rs].busy && !bypass;
        assign lk_tag[s*TAG_W +: TAG_W] = lk_busy[s] ? ent_q[rs].tag : '0;
        assign lk_value[s*XLEN +: XLEN] = (!bus.rn_src_valid[s] || lk_busy[s]) ? '0 :
                                          bypass ? bus.cm_value : value_q[rs];
    end

    always_comb begin
        ent_d = mispredict ? restore : ent_q;
        if (!mispredict && cm_hit && ent_q[bus.cm_dest].tag == bus.cm_tag) begin
            ent_d[bus.cm_dest].busy = 1'b0;
        end
        if (accept && bus.rn_dest_valid && bus.rn_dest_reg != '0) begin
            ent_d[bus.rn_dest_reg].busy = 1'b1;
            ent_d[bus.rn_dest_reg].tag  = bus.rn_dest_tag;
        end
        if (bus.flush) begin
            for (int r = 0; r < NREG; r++) ent_d[r].busy = 1'b0;
        end
        ent_d[0] = '0;
    end

    rename_ckpt_bank #(
        .NREG  (NREG),
        .TAG_W (TAG_W),
        .NCKPT (NCKPT)
    ) u_bank (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (bus.rdy),
        .flush         (bus.flush),
        .alloc         (alloc),
        .snap          (ent_d),
        .br_valid      (bus.br_valid),
        .br_mispredict (bus.br_mispredict),
        .br_id         (bus.br_id),
        .cm_valid      (bus.cm_valid),
        .cm_dest       (bus.cm_dest),
        .cm_tag        (bus.cm_tag),
        .restore       (restore),
        .tail          (tail),
        .full          (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q        <= '0;
            for (int r = 0; r < NREG; r++) value_q[r] <= '0;
            rn_done_q    <= 1'b0;
            rn_done_id_q <= '0;
            src_busy_q   <= '0;
            src_tag_q    <= '0;
            src_value_q  <= '0;
            ckpt_id_q    <= '0;
        end else if (bus.rdy) begin
            ent_q     <= ent_d;
            if (cm_hit) value_q[bus.cm_dest] <= bus.cm_value;
            rn_done_q <= accept;
            if (accept) begin
                rn_done_id_q <= bus.rn_id;
                src_busy_q   <= lk_busy;
                src_tag_q    <= lk_tag;
                src_value_q  <= lk_value;
            end
            if (alloc) ckpt_id_q <= tail;
        end
    end

    assign bus.rn_done    = rn_done_q;
    assign bus.rn_done_id = rn_done_id_q;
    assign bus.src_busy   = src_busy_q;
    assign bus.src_tag    = src_tag_q;
    assign bus.src_value  = src_value_q;
    assign bus.ckpt_id    = ckpt_id_q;
    assign bus.ckpt_full  = full;

    a_ckpt_not_full: assert property (@(posedge clk) disable iff (!rst_n)
        bus.rdy && bus.rn_valid && bus.rn_ckpt |-> !full);

endmodule

// File: tb/tb_rename_table.sv
// Directed scoreboard bench for rename_table: stimulus pushes expected lookups,
// a negedge monitor pops and compares them whenever rn_done is seen.
module tb_rename_table;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rename_table_if #(.XLEN(32), .NREG(32), .TAG_W(4), .NSRC(2), .NCKPT(4)) ifc ();

    rename_table #(.XLEN(32), .NREG(32), .TAG_W(4), .NSRC(2), .NCKPT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  en;
        logic [1:0]  busy;
        logic [3:0]  tag0, tag1;
        logic [31:0] val0, val1;
        logic        chk_ck;
        logic [1:0]  ck;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        ifc.cm_valid = 0; ifc.cm_dest = '0; ifc.cm_tag = '0; ifc.cm_value = '0;
        ifc.flush = 0; ifc.rn_valid = 0; ifc.rn_id = '0; ifc.rn_src_valid = '0;
        ifc.rn_src_reg = '0; ifc.rn_dest_valid = 0; ifc.rn_dest_reg = '0;
        ifc.rn_dest_tag = '0; ifc.rn_ckpt = 0; ifc.br_valid = 0; ifc.br_id = '0;
        ifc.br_mispredict = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rq(input logic [3:0] id, input logic [1:0] en, input logic [4:0] r0,
                      input logic [4:0] r1, input logic dv, input logic [4:0] rd,
                      input logic [3:0] dt, input logic ck);
        ifc.rn_valid = 1; ifc.rn_id = id; ifc.rn_src_valid = en;
        ifc.rn_src_reg = {r1, r0}; ifc.rn_dest_valid = dv; ifc.rn_dest_reg = rd;
        ifc.rn_dest_tag = dt; ifc.rn_ckpt = ck;
    endtask

    task automatic cm(input logic [4:0] d, input logic [3:0] t, input logic [31:0] v);
        ifc.cm_valid = 1; ifc.cm_dest = d; ifc.cm_tag = t; ifc.cm_value = v;
    endtask

    task automatic br(input logic [1:0] id, input logic mis);
        ifc.br_valid = 1; ifc.br_id = id; ifc.br_mispredict = mis;
    endtask

    task automatic ex(input logic [3:0] id, input logic [1:0] en, input logic [1:0] b,
                      input logic [3:0] t0, input logic [31:0] v0, input logic [3:0] t1,
                      input logic [31:0] v1, input logic c, input logic [1:0] ck);
        exp_t x;
        x.id = id; x.en = en; x.busy = b; x.tag0 = t0; x.val0 = v0;
        x.tag1 = t1; x.val1 = v1; x.chk_ck = c; x.ck = ck;
        q.push_back(x);
    endtask

    // Monitor: every rn_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && ifc.rn_done) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got id %0d expected no result", ifc.rn_done_id);
            end else begin
                e = q.pop_front();
                chk("done_id", 32'(ifc.rn_done_id), 32'(e.id));
                if (e.en[0]) begin
                    chk("src0_busy", 32'(ifc.src_busy[0]), 32'(e.busy[0]));
                    if (e.busy[0]) chk("src0_tag", 32'(ifc.src_tag[3:0]), 32'(e.tag0));
                    else           chk("src0_value", ifc.src_value[31:0], e.val0);
                end
                if (e.en[1]) begin
                    chk("src1_busy", 32'(ifc.src_busy[1]), 32'(e.busy[1]));
                    if (e.busy[1]) chk("src1_tag", 32'(ifc.src_tag[7:4]), 32'(e.tag1));
                    else           chk("src1_value", ifc.src_value[63:32], e.val1);
                end
                if (e.chk_ck) chk("ckpt_id", 32'(ifc.ckpt_id), 32'(e.ck));
            end
        end
    end

    initial begin
        idle();
        ifc.rdy = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(ifc.rn_done), 0);
        chk("rst_done_id", 32'(ifc.rn_done_id), 0);
        chk("rst_src_busy", 32'(ifc.src_busy), 0);
        chk("rst_src_tag", 32'(ifc.src_tag), 0);
        chk("rst_src_value", ifc.src_value[31:0], 0);
        chk("rst_ckpt_full", 32'(ifc.ckpt_full), 0);
        chk("rst_ckpt_id", 32'(ifc.ckpt_id), 0);
        rst_n = 1;
        tick();

        // Rename x5->3, lookup busy, commit 0x11, lookup value.
        rq(1, 2'b01, 5, 0, 1, 5, 3, 0); ex(1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0); tick();
        rq(2, 2'b01, 5, 0, 0, 0, 0, 0); ex(2, 2'b01, 2'b01, 3, 0, 0, 0, 0, 0); tick();
        cm(5, 3, 32'h11); tick();
        rq(3, 2'b01, 5, 0, 0, 0, 0, 0); ex(3, 2'b01, 2'b00, 0, 32'h11, 0, 0, 0, 0); tick();
        // Bypass on same-cycle commit, then stale-tag commit leaves x5 busy.
        rq(4, 2'b00, 0, 0, 1, 5, 3, 0); ex(4, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0); tick();
        cm(5, 3, 32'h22);
        rq(5, 2'b01, 5, 0, 0, 0, 0, 0); ex(5, 2'b01, 2'b00, 0, 32'h22, 0, 0, 0, 0); tick();
        rq(6, 2'b01, 5, 0, 1, 5, 3, 0); ex(6, 2'b01, 2'b00, 0, 32'h22, 0, 0, 0, 0); tick();
        cm(5, 2, 32'h33);
        rq(7, 2'b11, 5, 0, 0, 0, 0, 0); ex(7, 2'b11, 2'b01, 3, 0, 0, 0, 0, 0); tick();
        rq(8, 2'b11, 5, 5, 0, 0, 0, 0); ex(8, 2'b11, 2'b11, 3, 0, 3, 0, 0, 0); tick();
        // rd == rs returns the old producer.
        rq(9, 2'b00, 0, 0, 1, 7, 1, 0); ex(9, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0); tick();
        rq(10, 2'b01, 7, 0, 1, 7, 4, 0); ex(10, 2'b01, 2'b01, 1, 0, 0, 0, 0, 0); tick();
        rq(11, 2'b01, 7, 0, 0, 0, 0, 0); ex(11, 2'b01, 2'b01, 4, 0, 0, 0, 0, 0); tick();
        // Same-cycle commit and re-rename: lookup bypasses, rename wins the busy bit.
        cm(7, 4, 32'h44);
        rq(12, 2'b01, 7, 0, 1, 7, 5, 0); ex(12, 2'b01, 2'b00, 0, 32'h44, 0, 0, 0, 0); tick();
        rq(13, 2'b01, 7, 0, 0, 0, 0, 0); ex(13, 2'b01, 2'b01, 5, 0, 0, 0, 0, 0); tick();

        // Checkpoint after x8->5, rename x8->6, commit tag 5, mispredict slot 0.
        rq(14, 2'b00, 0, 0, 1, 8, 5, 1); ex(14, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0); tick();
        rq(15, 2'b00, 0, 0, 1, 8, 6, 0); ex(15, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0); tick();
        cm(8, 5, 32'h55); tick();
        br(0, 1); rq(0, 2'b01, 8, 0, 1, 9, 9, 0); tick();
        rq(1, 2'b11, 8, 7, 0, 0, 0, 0); ex(1, 2'b11, 2'b10, 0, 32'h55, 5, 0, 0, 0); tick();
        chk("ckpt_full_after_restore", 32'(ifc.ckpt_full), 0);

        // Fill all slots, then free them by correct resolution.
        for (int i = 0; i < 4; i++) begin
            rq(4'(2 + i), 2'b00, 0, 0, 0, 0, 0, 1);
            ex(4'(2 + i), 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'(i));
            tick();
        end
        chk("ckpt_full_filled", 32'(ifc.ckpt_full), 1);
        br(1, 0); tick();
        chk("ckpt_full_non_tail_freed", 32'(ifc.ckpt_full), 1);
        br(0, 0); tick();
        chk("ckpt_full_tail_freed", 32'(ifc.ckpt_full), 0);
        rq(6, 2'b00, 0, 0, 0, 0, 0, 1); ex(6, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0); tick();
        chk("ckpt_full_realloc", 32'(ifc.ckpt_full), 0);
        br(2, 1); tick();
        chk("ckpt_full_after_mis2", 32'(ifc.ckpt_full), 0);

        // rdy low: request and commit both ignored.
        tick();
        ifc.rdy = 0;
        cm(5, 3, 32'h66); rq(7, 2'b01, 5, 0, 1, 9, 7, 0); tick();
        tick();
        ifc.rdy = 1;
        rq(8, 2'b11, 5, 9, 0, 0, 0, 0); ex(8, 2'b11, 2'b01, 3, 0, 0, 0, 0, 0); tick();

        // Flush drops a coinciding request and clears every busy bit.
        ifc.flush = 1; rq(9, 2'b01, 5, 0, 1, 10, 8, 0); tick();
        rq(10, 2'b11, 5, 10, 0, 0, 0, 0); ex(10, 2'b11, 2'b00, 0, 32'h33, 0, 0, 0, 0); tick();
        chk("ckpt_full_after_flush", 32'(ifc.ckpt_full), 0);

        // Async reset with a result just registered.
        rq(11, 2'b01, 5, 0, 1, 5, 9, 1);
        @(posedge clk);
        #1;
        rst_n = 0;
        idle();
        #1;
        chk("midreset_done", 32'(ifc.rn_done), 0);
        chk("midreset_ckpt_full", 32'(ifc.ckpt_full), 0);
        @(negedge clk);
        #1;
        rst_n = 1;
        tick();
        rq(12, 2'b11, 5, 0, 0, 0, 0, 0); ex(12, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0); tick();

        repeat (3) tick();
        chk("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
